// File: rtl/ram_sample_player.sv
// ram_sample_player: reads a 16-bit waveform out of block RAM, one 32-bit word
// per sample period, and presents each sample with a one-cycle strobe. Playback
// is single-shot or looping; the RAM port is read-only.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for play_start; config latched on a valid start
// S_FETCH | bram_en high, address = index*4
// S_WAIT  | read data arrives; sample/strobe registered at cycle end
// S_HOLD  | sample period countdown, then next word / wrap / finish
// S_DONE  | one cycle before returning to idle; done pulses on exit
module ram_sample_player #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             play_start,
  input  logic             stop,
  input  logic             loop,
  input  logic [31:0]      len,
  input  logic [DIV_W-1:0] div,
  output logic [31:0]      bram_addr,
  output logic             bram_en,
  output logic [3:0]       bram_we,
  output logic [31:0]      bram_dout,
  output logic             bram_rst,
  input  logic [31:0]      bram_din,
  output logic [15:0]      sample,
  output logic             sample_valid,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_HOLD  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_next;

  logic [29:0]      r_words;
  logic [DIV_W-1:0] r_period;
  logic             r_loop;
  logic [29:0]      r_index;
  logic [DIV_W-1:0] r_cnt;
  logic [15:0]      r_sample;
  logic             r_sample_valid;
  logic             r_done;

  logic             w_start;
  logic [29:0]      w_words_in;
  logic [DIV_W-1:0] w_period_in;
  logic             w_last;
  logic             w_cnt_zero;
  logic             w_unused;

  assign w_words_in  = len[31:2];
  assign w_period_in = (div < DIV_W'(3)) ? DIV_W'(3) : div;
  assign w_start     = (r_state == S_IDLE) && play_start && !stop;
  assign w_last      = (r_index == (r_words - 30'd1));
  assign w_cnt_zero  = (r_cnt == '0);
  assign w_unused    = ^{bram_din[31:16], len[1:0]};

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state decode; stop returns any active state to idle
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start && (w_words_in != 30'd0)) w_next = S_FETCH;
      S_FETCH: w_next = S_WAIT;
      S_WAIT:  w_next = S_HOLD;
      S_HOLD: begin
        if (w_cnt_zero) begin
          if (w_last && !r_loop) w_next = S_DONE;
          else                   w_next = S_FETCH;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (stop && (r_state != S_IDLE)) w_next = S_IDLE;
  end

  // Config latch, word index, period timer and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_words        <= '0;
      r_period       <= '0;
      r_loop         <= 1'b0;
      r_index        <= '0;
      r_cnt          <= '0;
      r_sample       <= '0;
      r_sample_valid <= 1'b0;
      r_done         <= 1'b0;
    end else begin
      r_sample_valid <= 1'b0;
      r_done         <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_words  <= w_words_in;
            r_period <= w_period_in;
            r_loop   <= loop;
            r_index  <= '0;
            if (w_words_in == 30'd0) r_done <= 1'b1;
          end
        end
        S_WAIT: begin
          if (!stop) begin
            r_sample       <= bram_din[15:0];
            r_sample_valid <= 1'b1;
            // The final word of a one-shot run holds one extra cycle so that
            // done lands exactly one sample period after the last strobe.
            if (w_last && !r_loop) r_cnt <= r_period - DIV_W'(2);
            else                   r_cnt <= r_period - DIV_W'(3);
          end
        end
        S_HOLD: begin
          if (!stop) begin
            if (!w_cnt_zero)   r_cnt   <= r_cnt - DIV_W'(1);
            else if (!w_last)  r_index <= r_index + 30'd1;
            else if (r_loop)   r_index <= '0;
          end
        end
        S_DONE: begin
          if (!stop) r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bram_addr    = {r_index, 2'b00};
  assign bram_en      = (r_state == S_FETCH) && !stop;
  assign bram_we      = 4'b0000;
  assign bram_dout    = 32'd0;
  assign bram_rst     = 1'b0;
  assign sample       = r_sample;
  assign sample_valid = r_sample_valid;
  assign busy         = (r_state != S_IDLE);
  assign done         = r_done;

endmodule
